pll_lock_reset_seq: RTL and testbench

//  Consumes the asynchronous LOCK output of the board PLL. Produces staggered, synchronous,

---
 rtl/pll_lock_reset_seq_pkg.sv | 19 +
 rtl/pll_lock_reset_seq_if.sv | 23 ++
 rtl/pll_lock_reset_seq_sync_ff.sv | 19 +
 rtl/pll_lock_reset_seq.sv | 156 +++++++++++++++
 tb/tb_pll_lock_reset_seq.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/pll_lock_reset_seq_pkg.sv
// Shared definitions for the PLL lock / domain reset sequencer:
// FSM state encoding and the counter-width helper.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        LOST      = 3'd4,
        PLLRST    = 3'd5
    } pll_state_t;

    // Bits needed for a counter that runs 0 .. n-1 (never narrower than 1).
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pll_lock_reset_seq_if.sv
// Status/reset bundle between the PLL lock sequencer and the rest of the board logic.
// The sequencer is the master: it consumes LOCK and drives the resets.
interface pll_lock_reset_seq_if #(
    parameter int N_RST      = 4,
    parameter int LOSS_CNT_W = 8
);
    logic                  locked_async;
    logic                  pll_rst;
    logic [N_RST-1:0]      rst_out;
    logic                  ready;
    logic [LOSS_CNT_W-1:0] loss_count;
    logic [2:0]            state_o;

    modport master (
        input  locked_async,
        output pll_rst, rst_out, ready, loss_count, state_o
    );

    modport slave (
        output locked_async,
        input  pll_rst, rst_out, ready, loss_count, state_o
    );
endinterface

// File: rtl/pll_lock_reset_seq_sync_ff.sv
// Multi-flop bit synchronizer with synchronous active-low clear, for any
// asynchronous status input. STAGES must be at least 2.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_p;

    always_ff @(posedge clk) begin
        if (!resetn) sync_p <= '0;
        else         sync_p <= {sync_p[STAGES-2:0], d};
    end

    assign q = sync_p[STAGES-1];
endmodule

// File: rtl/pll_lock_reset_seq.sv
// Qualifies PLL lock on the free-running board clock and releases the PLL-clocked
// domain resets one by one; re-asserts them on lock loss and re-kicks the PLL on timeout.
module pll_lock_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 1024,
    parameter int N_RST          = 4,
    parameter int STAGGER        = 16,
    parameter int RELOCK_TIMEOUT = 65536,
    parameter int PLLRST_CYCLES  = 8,
    parameter int LOSS_CNT_W     = 8
) (
    input logic                  clk,
    input logic                  resetn,
    pll_lock_reset_seq_if.master bus
);
    localparam int SW = cnt_w(STABLE_CYCLES);
    localparam int GW = cnt_w(STAGGER);
    localparam int IW = cnt_w(N_RST);
    localparam int TW = cnt_w(RELOCK_TIMEOUT);
    localparam int PW = cnt_w(PLLRST_CYCLES);

    localparam logic [SW-1:0]    STABLE_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [GW-1:0]    STAG_LAST   = GW'(STAGGER - 1);
    localparam logic [IW-1:0]    IDX_LAST    = IW'(N_RST - 1);
    localparam logic [TW-1:0]    TO_LAST     = TW'(RELOCK_TIMEOUT - 1);
    localparam logic [PW-1:0]    PLL_LAST    = PW'(PLLRST_CYCLES - 1);
    localparam logic [N_RST-1:0] ALL_RST     = '1;
    localparam logic [N_RST-1:0] ONE_RST     = N_RST'(1);

    function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic lock_s;

    pll_state_t            state, state_n;
    logic [SW-1:0]         stable_cnt, stable_n;
    logic [GW-1:0]         stag_cnt, stag_n;
    logic [IW-1:0]         idx, idx_n;
    logic [TW-1:0]         to_cnt, to_n;
    logic [PW-1:0]         pll_cnt, pll_n;
    logic [N_RST-1:0]      rst_r, rst_n;
    logic [LOSS_CNT_W-1:0] loss_r, loss_n;
    logic                  ready_r, pll_rst_r;

    sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (bus.locked_async),
        .q      (lock_s)
    );

    always_comb begin
        state_n  = state;
        stable_n = stable_cnt;
        stag_n   = stag_cnt;
        idx_n    = idx;
        to_n     = to_cnt;
        pll_n    = pll_cnt;
        rst_n    = rst_r;
        loss_n   = loss_r;

        case (state)
            WAIT_LOCK: begin
                rst_n = ALL_RST;
                if (lock_s) begin
                    state_n  = STABLE;
                    stable_n = '0;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_n = WAIT_LOCK;
                end else if (stable_cnt == STABLE_LAST) begin
                    state_n = RELEASE;
                    idx_n   = '0;
                    stag_n  = '0;
                end else begin
                    stable_n = stable_cnt + 1'b1;
                end
            end
            RELEASE, RUN: begin
                // A drop always beats a release due on the same edge.
                if (!lock_s) begin
                    state_n = LOST;
                    rst_n   = ALL_RST;
                    loss_n  = sat_inc(loss_r);
                    to_n    = '0;
                end else if (state == RELEASE) begin
                    if (stag_cnt == STAG_LAST) begin
                        rst_n  = rst_r & ~(ONE_RST << idx);
                        stag_n = '0;
                        if (idx == IDX_LAST) state_n = RUN;
                        else                 idx_n   = idx + 1'b1;
                    end else begin
                        stag_n = stag_cnt + 1'b1;
                    end
                end
            end
            LOST: begin
                if (lock_s) begin
                    state_n  = STABLE;
                    stable_n = '0;
                end else if (to_cnt == TO_LAST) begin
                    state_n = PLLRST;
                    pll_n   = '0;
                end else begin
                    to_n = to_cnt + 1'b1;
                end
            end
            PLLRST: begin
                if (pll_cnt == PLL_LAST) state_n = WAIT_LOCK;
                else                     pll_n   = pll_cnt + 1'b1;
            end
            default: begin
                state_n = WAIT_LOCK;
                rst_n   = ALL_RST;
            end
        endcase
    end

    // ready and pll_rst are decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= WAIT_LOCK;
            stable_cnt <= '0;
            stag_cnt   <= '0;
            idx        <= '0;
            to_cnt     <= '0;
            pll_cnt    <= '0;
            rst_r      <= ALL_RST;
            loss_r     <= '0;
            ready_r    <= 1'b0;
            pll_rst_r  <= 1'b0;
        end else begin
            state      <= state_n;
            stable_cnt <= stable_n;
            stag_cnt   <= stag_n;
            idx        <= idx_n;
            to_cnt     <= to_n;
            pll_cnt    <= pll_n;
            rst_r      <= rst_n;
            loss_r     <= loss_n;
            ready_r    <= (state_n == RUN);
            pll_rst_r  <= (state_n == PLLRST);
        end
    end

    assign bus.rst_out    = rst_r;
    assign bus.pll_rst    = pll_rst_r;
    assign bus.ready      = ready_r;
    assign bus.loss_count = loss_r;
    assign bus.state_o    = state;
endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Bench for pll_lock_reset_seq: directed lock patterns push the expected output changes
// (with the cycle they must appear on) into a queue; a monitor pops one per observed change.
module tb_pll_lock_reset_seq;
    import pll_seq_pkg::*;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic [2:0] rst;
        logic       rdy;
        logic       prst;
        logic [1:0] loss;
        string      tag;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic done = 1'b0;
    logic fin_chk = 1'b0;
    exp_t q[$];

    pll_lock_reset_seq_if #(.N_RST(3), .LOSS_CNT_W(2)) bus ();

    pll_lock_reset_seq #(
        .SYNC_STAGES    (2),
        .STABLE_CYCLES  (8),
        .N_RST          (3),
        .STAGGER        (2),
        .RELOCK_TIMEOUT (20),
        .PLLRST_CYCLES  (4),
        .LOSS_CNT_W     (2)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [9:0] cur;
    logic [9:0] prev = 'x;
    assign cur = {bus.state_o, bus.rst_out, bus.ready, bus.pll_rst, bus.loss_count};

    // Monitor: every change of the output tuple is one transaction.
    always @(negedge clk) begin
        exp_t       e;
        logic [9:0] want;
        if (cur !== prev) begin
            vectors <= vectors + 1;
            if (q.size() == 0) begin
                miscompares <= miscompares + 1;
                $display("FAIL unexpected @cyc %0d: got st=%0d rst=%b rdy=%b prst=%b loss=%0d, none expected",
                         cyc, cur[9:7], cur[6:4], cur[3], cur[2], cur[1:0]);
            end else begin
                e = q.pop_front();
                want = {e.st, e.rst, e.rdy, e.prst, e.loss};
                if (cur !== want || cyc != e.cyc)
                begin
                    miscompares <= miscompares + 1;
                    $display("FAIL %s: got st=%0d rst=%b rdy=%b prst=%b loss=%0d cyc=%0d, want st=%0d rst=%b rdy=%b prst=%b loss=%0d cyc=%0d",
                             e.tag, cur[9:7], cur[6:4], cur[3], cur[2], cur[1:0], cyc,
                             e.st, e.rst, e.rdy, e.prst, e.loss, e.cyc);
                end
            end
            prev <= cur;
        end else if (done && !fin_chk) begin
            fin_chk <= 1'b1;
            vectors <= vectors + 1;
            if (q.size() != 0) begin
                miscompares <= miscompares + 1;
                $display("FAIL pending: got %0d expected changes never seen (next %s at cyc %0d), want 0",
                         q.size(), q[0].tag, q[0].cyc);
            end
        end
    end

    task automatic ex(input int c, input logic [2:0] st, input logic [2:0] r, input logic rd,
                      input logic pr, input logic [1:0] l, input string tag);
        exp_t e;
        e = '{c, st, r, rd, pr, l, tag};
        q.push_back(e);
    endtask

    task automatic at_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Drop at d, relock at d+2, from RUN with loss already saturated.
    task automatic drop_relock(input int d);
        ex(d + 3,  LOST,    3'b111, 1'b0, 1'b0, 2'd3, "sat_lost");
        ex(d + 5,  STABLE,  3'b111, 1'b0, 1'b0, 2'd3, "sat_stable");
        ex(d + 13, RELEASE, 3'b111, 1'b0, 1'b0, 2'd3, "sat_release");
        ex(d + 15, RELEASE, 3'b110, 1'b0, 1'b0, 2'd3, "sat_bit0");
        ex(d + 17, RELEASE, 3'b100, 1'b0, 1'b0, 2'd3, "sat_bit1");
        ex(d + 19, RUN,     3'b000, 1'b1, 1'b0, 2'd3, "sat_run");
        at_cyc(d);
        bus.locked_async = 1'b0;
        at_cyc(d + 2);
        bus.locked_async = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        bus.locked_async = 1'b0;
        ex(1, WAIT_LOCK, 3'b111, 1'b0, 1'b0, 2'd0, "reset_state");

        // Clean lock right after reset release.
        ex(6,  STABLE,  3'b111, 1'b0, 1'b0, 2'd0, "t1_stable");
        ex(14, RELEASE, 3'b111, 1'b0, 1'b0, 2'd0, "t1_release");
        ex(16, RELEASE, 3'b110, 1'b0, 1'b0, 2'd0, "t1_bit0");
        ex(18, RELEASE, 3'b100, 1'b0, 1'b0, 2'd0, "t1_bit1");
        ex(20, RUN,     3'b000, 1'b1, 1'b0, 2'd0, "t1_run");
        at_cyc(3);
        resetn = 1'b1;
        bus.locked_async = 1'b1;

        // Drop in RUN, relock after 6 cycles.
        ex(28, LOST,    3'b111, 1'b0, 1'b0, 2'd1, "t3_lost");
        ex(34, STABLE,  3'b111, 1'b0, 1'b0, 2'd1, "t3_stable");
        ex(42, RELEASE, 3'b111, 1'b0, 1'b0, 2'd1, "t3_release");
        ex(44, RELEASE, 3'b110, 1'b0, 1'b0, 2'd1, "t3_bit0");
        ex(46, RELEASE, 3'b100, 1'b0, 1'b0, 2'd1, "t3_bit1");
        ex(48, RUN,     3'b000, 1'b1, 1'b0, 2'd1, "t3_run");
        at_cyc(25);
        bus.locked_async = 1'b0;
        at_cyc(31);
        bus.locked_async = 1'b1;

        // Drop in RUN, no relock: timeout, 4-cycle PLL reset pulse.
        ex(55, LOST,      3'b111, 1'b0, 1'b0, 2'd2, "t4_lost");
        ex(75, PLLRST,    3'b111, 1'b0, 1'b1, 2'd2, "t4_pllrst");
        ex(79, WAIT_LOCK, 3'b111, 1'b0, 1'b0, 2'd2, "t4_wait");
        at_cyc(52);
        bus.locked_async = 1'b0;

        // Bounce during qualification, then a drop on the edge bit 1 is due.
        ex(85,  STABLE,    3'b111, 1'b0, 1'b0, 2'd2, "t2_stable");
        ex(90,  WAIT_LOCK, 3'b111, 1'b0, 1'b0, 2'd2, "t2_bounce");
        ex(91,  STABLE,    3'b111, 1'b0, 1'b0, 2'd2, "t2_restable");
        ex(99,  RELEASE,   3'b111, 1'b0, 1'b0, 2'd2, "t2_release");
        ex(101, RELEASE,   3'b110, 1'b0, 1'b0, 2'd2, "t2_bit0");
        ex(103, LOST,      3'b111, 1'b0, 1'b0, 2'd3, "t5_drop_wins");
        ex(109, STABLE,    3'b111, 1'b0, 1'b0, 2'd3, "t5_stable");
        ex(117, RELEASE,   3'b111, 1'b0, 1'b0, 2'd3, "t5_release");
        ex(119, RELEASE,   3'b110, 1'b0, 1'b0, 2'd3, "t5_bit0");
        ex(121, RELEASE,   3'b100, 1'b0, 1'b0, 2'd3, "t5_bit1");
        ex(123, RUN,       3'b000, 1'b1, 1'b0, 2'd3, "t5_run");
        at_cyc(82);
        bus.locked_async = 1'b1;
        at_cyc(87);
        bus.locked_async = 1'b0;
        at_cyc(88);
        bus.locked_async = 1'b1;
        at_cyc(100);
        bus.locked_async = 1'b0;
        at_cyc(106);
        bus.locked_async = 1'b1;

        // Four more drop/relock rounds keep loss_count pinned at 3.
        for (int i = 0; i < 4; i++) drop_relock(126 + 22 * i);

        // Fifth drop with no relock, then reset in the middle of the PLL pulse.
        ex(217, LOST,      3'b111, 1'b0, 1'b0, 2'd3, "t6_lost");
        ex(237, PLLRST,    3'b111, 1'b0, 1'b1, 2'd3, "t6_pllrst");
        ex(239, WAIT_LOCK, 3'b111, 1'b0, 1'b0, 2'd0, "t6_reset_abort");
        at_cyc(214);
        bus.locked_async = 1'b0;
        at_cyc(238);
        resetn = 1'b0;
        at_cyc(241);
        resetn = 1'b1;

        at_cyc(250);
        done = 1'b1;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
